// File: rtl/multi_mem_if.sv
// Bus between the pixel loader / display scanner and the multi_mem frame buffer.
//   master : drives the byte write port A and the wide read address of port B
//   slave  : the frame buffer; returns QB, the registered read data
// AW = byte address width, BW = pixel-position width, DW = read data width.
interface multi_mem_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned BW = 10,
  parameter int unsigned DW = 32
);
  logic [7:0]    DataInA;
  logic [AW-1:0] AddressA;
  logic          ClockEnA;
  logic          WrA;
  logic [BW-1:0] AddressB;
  logic          ClockEnB;
  logic [DW-1:0] QB;

  modport master (
    output DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
    input  QB
  );

  modport slave (
    input  DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
    output QB
  );
endinterface

// File: rtl/multi_mem.sv
// Frame-buffer RAM: byte-wide write port A, wide read port B returning every
// byte of one pixel position for all panel sections in a single access.
// Ports:
//   Clock : sole clock, rising edge
//   Reset : asynchronous active-high; clears the read register only
//   bus   : multi_mem_if slave (DataInA/AddressA/ClockEnA/WrA write port,
//           AddressB/ClockEnB read port, QB registered read data)
module multi_mem #(
  parameter int unsigned PIXEL_HEIGHT     = 32,
  parameter int unsigned PIXEL_WIDTH      = 64,
  parameter int unsigned BYTES_PER_PIXEL  = 2,
  parameter int unsigned PIXEL_HALFHEIGHT = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  multi_mem_if.slave  bus
);

  localparam int unsigned SECTIONS = PIXEL_HEIGHT / PIXEL_HALFHEIGHT;
  localparam int unsigned LANES    = SECTIONS * BYTES_PER_PIXEL;
  localparam int unsigned AW       = $clog2(PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL);
  localparam int unsigned BW       = AW - $clog2(LANES);
  localparam int unsigned BSW      = $clog2(BYTES_PER_PIXEL);
  localparam int unsigned LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned DEPTH    = 2 ** BW;

  logic [LW-1:0] wr_lane;
  logic [BW-1:0] wr_pos;
  logic          wr_go;

  // AddressA = {section, position, byte_sel}; lane = {section, byte_sel}
  always_comb begin
    wr_pos  = BW'(bus.AddressA >> BSW);
    wr_lane = LW'(((bus.AddressA >> (BW + BSW)) << BSW) |
                  (bus.AddressA & AW'(BYTES_PER_PIXEL - 1)));
    wr_go   = bus.ClockEnA && bus.WrA && !Reset;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Write port: contents are never reset, only gated off while Reset is high
    always_ff @(posedge Clock) begin
      if (wr_go && (wr_lane == LW'(k))) begin
        mem[wr_pos] <= bus.DataInA;
      end
    end

    // Registered read port; nonblocking read gives pre-write data on a collision
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        rd_q <= '0;
      end else if (bus.ClockEnB) begin
        rd_q <= mem[bus.AddressB];
      end
    end

    assign bus.QB[k*8 +: 8] = rd_q;
  end

endmodule

// File: tb/tb_multi_mem.sv
// Self-checking bench for multi_mem: a byte-addressed reference model supplies
// expected read words, queued when a read is issued and compared one edge later.
module tb_multi_mem;

  localparam int unsigned AW = 12;
  localparam int unsigned BW = 10;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_mem_if #(.AW(AW), .BW(BW), .DW(DW)) bus ();

  multi_mem dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] model [2**AW];
  bit         valid [2**AW];
  exp_t       sb [$];
  exp_t       last_exp;
  int         vectors     = 0;
  int         miscompares = 0;

  // Expected QB for a read of pixel position ra; lanes never written are masked
  function automatic exp_t expect_read(input logic [BW-1:0] ra);
    exp_t e;
    e.data = '0;
    e.mask = '0;
    for (int k = 0; k < 4; k++) begin
      int a;
      a = ((k >> 1) << 11) | (int'(ra) << 1) | (k & 1);
      if (valid[a]) begin
        e.data[k*8 +: 8] = model[a];
        e.mask[k*8 +: 8] = 8'hFF;
      end
    end
    return e;
  endfunction

  // Drive one clock of stimulus; expected data is captured before the model write
  task automatic cycle(input logic ena, input logic wr, input logic [AW-1:0] wa,
                       input logic [7:0] wd, input logic re, input logic [BW-1:0] ra);
    bus.ClockEnA = ena;
    bus.WrA      = wr;
    bus.AddressA = wa;
    bus.DataInA  = wd;
    bus.ClockEnB = re;
    bus.AddressB = ra;
    if (re && !rst) sb.push_back(expect_read(ra));
    if (ena && wr && !rst) begin
      model[wa] = wd;
      valid[wa] = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.ClockEnA = 1'b0;
    bus.WrA      = 1'b0;
    bus.ClockEnB = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
      vectors++;
      if (bus.QB !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_held: QB=%h expected=%h", bus.QB, 32'h0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
      vectors++;
      if (bus.QB !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_release: QB=%h expected=%h", bus.QB, 32'h0);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    cycle(1'b1, 1'b1, 12'hFFF, 8'h41, 1'b0, '0);
    cycle(1'b1, 1'b1, 12'hFFE, 8'h42, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if ((bus.QB & e.mask) !== e.data || bus.QB[31:16] !== 16'h4142) begin
      miscompares++;
      $display("FAIL write_read: QB=%h expected=%h mask=%h", bus.QB, e.data, e.mask);
    end
    cycle(1'b1, 1'b1, 12'hFFF, 8'h43, 1'b0, '0);
    // Enabled port without write strobe must not write
    cycle(1'b1, 1'b0, 12'hFFF, 8'h77, 1'b0, '0);
    cycle(1'b0, 1'b1, 12'hFFE, 8'h78, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if ((bus.QB & e.mask) !== e.data || bus.QB[31:16] !== 16'h4342) begin
      miscompares++;
      $display("FAIL overwrite: QB=%h expected=%h mask=%h", bus.QB, e.data, e.mask);
    end
    last_exp = e;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 12'h002 + AW'(i), 8'h10 + 8'(i), 1'b0, 10'(i));
      vectors++;
      if ((bus.QB & last_exp.mask) !== last_exp.data) begin
        miscompares++;
        $display("FAIL hold: QB=%h expected=%h", bus.QB, last_exp.data);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    logic [7:0] want [3] = '{8'h42, 8'h45, 8'h46};
    cycle(1'b1, 1'b1, 12'hFFE, 8'h45, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if ((bus.QB & e.mask) !== e.data || bus.QB[23:16] !== want[0]) begin
      miscompares++;
      $display("FAIL collide_old: QB=%h expected=%h", bus.QB, e.data);
    end
    cycle(1'b1, 1'b1, 12'hFFE, 8'h46, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if ((bus.QB & e.mask) !== e.data || bus.QB[23:16] !== want[1]) begin
      miscompares++;
      $display("FAIL collide_next: QB=%h expected=%h", bus.QB, e.data);
    end
    // Write elsewhere on the same edge must not disturb the read
    cycle(1'b1, 1'b1, 12'h7FC, 8'hAA, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if ((bus.QB & e.mask) !== e.data || bus.QB[23:16] !== want[2]) begin
      miscompares++;
      $display("FAIL collide_last: QB=%h expected=%h", bus.QB, e.data);
    end
  endtask

  task automatic test_section();
    exp_t e;
    cycle(1'b1, 1'b1, 12'h7FF, 8'h5A, 1'b0, '0);
    cycle(1'b1, 1'b1, 12'h7FE, 8'h59, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if ((bus.QB & e.mask) !== e.data || bus.QB !== 32'h43465A59) begin
      miscompares++;
      $display("FAIL section: QB=%h expected=%h", bus.QB, 32'h43465A59);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [AW-1:0] wa;
    logic [BW-1:0] ra;
    for (int i = 0; i < 40; i++) begin
      wa = AW'(($urandom_range(0, 1) << 11) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      ra = BW'($urandom_range(0, 7));
      cycle(1'b1, 1'($urandom_range(0, 1)), wa, 8'($urandom), 1'b1, ra);
      e = sb.pop_front();
      vectors++;
      if ((bus.QB & e.mask) !== e.data) begin
        miscompares++;
        $display("FAIL b2b[%0d]: QB=%h expected=%h mask=%h", i, bus.QB, e.data, e.mask);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if (bus.QB !== 32'h43465A59) begin
      miscompares++;
      $display("FAIL pre_reset: QB=%h expected=%h", bus.QB, 32'h43465A59);
    end
    bus.ClockEnB = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.QB !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: QB=%h expected=%h", bus.QB, 32'h0);
    end
    // Writes and reads while Reset is held are ignored
    cycle(1'b1, 1'b1, 12'hFFF, 8'h99, 1'b1, 10'h3FF);
    vectors++;
    if (bus.QB !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ignore: QB=%h expected=%h", bus.QB, 32'h0);
    end
    rst = 1'b0;
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF);
    e = sb.pop_front();
    vectors++;
    if ((bus.QB & e.mask) !== e.data || bus.QB !== 32'h43465A59) begin
      miscompares++;
      $display("FAIL retained: QB=%h expected=%h", bus.QB, 32'h43465A59);
    end
  endtask

  initial begin
    bus.DataInA  = '0;
    bus.AddressA = '0;
    bus.ClockEnA = 1'b0;
    bus.WrA      = 1'b0;
    bus.AddressB = '0;
    bus.ClockEnB = 1'b0;
    for (int i = 0; i < 2**AW; i++) valid[i] = 1'b0;
    #1;
    vectors++;
    if (bus.QB !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_initial: QB=%h expected=%h", bus.QB, 32'h0);
    end
    test_reset();
    test_write_read();
    test_hold();
    test_collision();
    test_section();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multi_mem.md
Name: multi_mem

Overview:
- Frame-buffer RAM with an asymmetric port pair: byte-wide write port A and a wide read port B.
- Port B returns every byte of one pixel position for all panel sections (top/bottom halves) in one access.
- Sits between the pixel-data loader (writes bytes) and the display scanner (reads one column of all halves per access).
- Single clock domain.

Parameters:
PIXEL_HEIGHT, 32, panel rows (power of two)
PIXEL_WIDTH, 64, panel columns (power of two)
BYTES_PER_PIXEL, 2, bytes per pixel (power of two)
PIXEL_HALFHEIGHT, 16, rows per scan section; SECTIONS = PIXEL_HEIGHT/PIXEL_HALFHEIGHT (power of two)
Derived: LANES = SECTIONS*BYTES_PER_PIXEL; AW = clog2(PIXEL_HEIGHT*PIXEL_WIDTH*BYTES_PER_PIXEL); BW = AW - clog2(LANES); DW = LANES*8

Ports:
Clock  in  1  sole clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high; clears read register only
DataInA  in  8  write byte
AddressA  in  AW  byte address
ClockEnA  in  1  port A enable
WrA  in  1  write strobe; write only when ClockEnA && WrA
AddressB  in  BW  pixel-position address within a section
ClockEnB  in  1  port B read enable
QB  out  DW  registered read data

Behaviour:
- Storage is LANES independent byte lanes, each 2^BW deep.
- AddressA decode, MSB to LSB: {section, position[BW-1:0], byte_sel}.
  - section is clog2(SECTIONS) bits; byte_sel is clog2(BYTES_PER_PIXEL) bits.
  - lane = {section, byte_sel}; lane address = position.
  - Default widths: AW=12 with section=A[11], position=A[10:1], byte_sel=A[0]; BW=10.
- Write: on rising Clock with ClockEnA=1 and WrA=1, lane[{section,byte_sel}][position] <= DataInA. No other lane changes.
  - ClockEnA=0 or WrA=0: no write.
- Read: on rising Clock with ClockEnB=1, QB <= concatenation of all lanes at AddressB.
  - Lane k occupies QB[8k+7:8k]. Default: QB = {sec1.byte1, sec1.byte0, sec0.byte1, sec0.byte0}.
  - Latency is one clock: data is visible after the edge that samples AddressB.
  - ClockEnB=0: QB holds its value.
- Read and write to the same location on the same edge: QB returns the old (pre-write) data. The new data is visible on the next read.
- Writes to other lanes or positions on the same edge as a read do not disturb QB.
- Reset asserted: QB = 0 immediately (asynchronous) and while held. Memory contents are preserved. Writes and reads are ignored while Reset=1.
- Reset deasserted mid-operation: normal operation resumes on the next rising edge.
- Memory has no defined power-up contents; reading an unwritten location returns unspecified data (X in simulation allowed).
- Address bits above the decoded widths are not present. Every AddressA value maps to exactly one lane/position, so there are no out-of-range cases.
- Implement lanes as inferable simple dual-port RAM (one write port, one registered read port per lane).

Test Plan:
- Reset pulse then idle, both enables low -> QB=0 throughout; QB stays 0 after release.
- Write 0xFFF<-'A'(0x41), then 0xFFE<-'B'(0x42); read AddressB=0x3FF with ClockEnB=1 -> one edge later QB[31:24]=0x41, QB[23:16]=0x42.
- Write 0xFFF<-'C' (0x43), then read 0x3FF -> QB[31:24]=0x43, QB[23:16]=0x42. Drop ClockEnB and change AddressB -> QB holds.
- Same edge: write 0xFFE<-'E' (0x45) and read 0x3FF -> QB[23:16] shows the prior value 0x42. Next edge, write 0xFFE<-'F' and read again -> QB[23:16]=0x45. The following read -> QB[23:16]=0x46.
- Section select: write 0x7FF<-'Z'(0x5A), 0x7FE<-'Y'(0x59), then read 0x3FF -> QB[15:8]=0x5A, QB[7:0]=0x59, QB[31:16] unchanged (section-1 data).
- Assert Reset while ClockEnB=1 and QB nonzero -> QB=0 without waiting for a clock edge. After release, read 0x3FF -> previously written bytes return (memory retained).
